// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serializer_pkg
// Purpose  : Shared FSM state type and bit-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // $clog2 with a floor of one bit so W=1 still has a legal counter.
  function automatic int calc_cw(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/mux_serializer_shift_cell.sv
`default_nettype none
// ============================================================================
// Module   : mux2 / shift_cell
// Purpose  : 2:1 mux cell and one shift-register bit built from two of them.
// Revision : 1.0 - initial release
// ============================================================================
module mux2 (
  input  logic i_d0,
  input  logic i_d1,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule : mux2

module shift_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic i_left,
  input  logic i_load_bit,
  input  logic i_shift_en,
  input  logic i_load_en,
  output logic o_q
);

  logic w_mux_a;
  logic w_mux_b;
  logic r_q;

  mux2 u_mux_a (
    .i_d0  (r_q),
    .i_d1  (i_left),
    .i_sel (i_shift_en),
    .o_y   (w_mux_a)
  );

  // Load takes priority over shift/hold.
  mux2 u_mux_b (
    .i_d0  (w_mux_a),
    .i_d1  (i_load_bit),
    .i_sel (i_load_en),
    .o_y   (w_mux_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_mux_b;
    end
  end

  assign o_q = r_q;

endmodule : shift_cell
`default_nettype wire

// File: rtl/mux_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mux_serializer
// Purpose  : Parallel-in, MSB-first serial-out shifter with valid/ready on
//            both sides and optional per-word output inversion.
// Revision : 1.0 - initial release
// ============================================================================
module mux_serializer
  import serializer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_data,
  input  logic         load_inv,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_data,
  output logic         ser_last
);

  localparam int CW = calc_cw(W);

  if ((W < 1) || (W > 32)) begin : g_bad_width
    $error("mux_serializer: W must be within 1..32");
  end

  ser_state_t     r_state;
  ser_state_t     w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic           r_inv;
  logic [W-1:0]   w_sreg;
  logic           w_load;
  logic           w_xfer;
  logic           w_cnt_zero;

  assign load_ready = (r_state == IDLE);
  assign ser_valid  = (r_state == SHIFT);
  assign w_load     = load_valid && load_ready;
  assign w_xfer     = ser_valid && ser_ready;
  assign w_cnt_zero = (r_cnt == '0);

  // Shifting on the final transfer too leaves the register all-zero for IDLE.
  for (genvar i = 0; i < W; i++) begin : g_cell
    logic w_left;
    if (i == 0) begin : g_lsb
      assign w_left = 1'b0;
    end else begin : g_upper
      assign w_left = w_sreg[i-1];
    end

    shift_cell u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_left     (w_left),
      .i_load_bit (load_data[i]),
      .i_shift_en (w_xfer),
      .i_load_en  (w_load),
      .o_q        (w_sreg[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = SHIFT;
      SHIFT:   if (w_xfer && w_cnt_zero) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_inv <= 1'b0;
    end else if (w_load) begin
      r_cnt <= CW'(W - 1);
      r_inv <= load_inv;
    end else if (w_xfer) begin
      if (w_cnt_zero) begin
        r_inv <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign ser_data = ser_valid & (w_sreg[W-1] ^ r_inv);
  assign ser_last = ser_valid & w_cnt_zero;

endmodule : mux_serializer
`default_nettype wire

// File: tb/tb_mux_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_serializer
// Purpose  : Directed self-checking bench for mux_serializer (W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_serializer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       load_inv;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_data;
  logic       ser_last;

  int n_checks = 0;
  int n_fail   = 0;

  mux_serializer #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_inv   (load_inv),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data),
    .ser_last   (ser_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads one word and consumes it; exp is the hand-computed serial stream, MSB first.
  task automatic send_word(input logic [7:0] data, input logic inv, input logic [7:0] exp,
                           input int stall_at, input int stall_len, input string tag);
    logic [7:0] e;
    e          = exp;
    load_data  = data;
    load_inv   = inv;
    load_valid = 1'b1;
    ser_ready  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_data  = 8'h5A;
    load_inv   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check({tag, "_valid"}, ser_valid, 1'b1);
      check({tag, "_data"}, ser_data, e[7-k]);
      check({tag, "_last"}, ser_last, (k == 7));
      if (k == stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check({tag, "_stall_data"}, ser_data, e[7-k]);
          check({tag, "_stall_last"}, ser_last, 1'b0);
        end
        ser_ready = 1'b1;
      end
      tick();
    end
    check({tag, "_done_ready"}, load_ready, 1'b1);
    check({tag, "_done_valid"}, ser_valid, 1'b0);
  endtask

  initial begin
    int cycles;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_inv   = 1'b0;
    ser_ready  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_ser_valid", ser_valid, 1'b0);
    check("rst_ser_data", ser_data, 1'b0);
    check("rst_ser_last", ser_last, 1'b0);

    // X on ser_ready while idle must not disturb anything
    ser_ready = 1'bx;
    tick();
    check("idle_x_valid", ser_valid, 1'b0);
    check("idle_x_ready", load_ready, 1'b1);

    send_word(8'hA5, 1'b0, 8'b1010_0101, -1, 0, "basic");
    send_word(8'h0F, 1'b1, 8'b1111_0000, -1, 0, "inv");
    send_word(8'hC3, 1'b0, 8'b1100_0011, 2, 5, "bp");

    // Back-to-back with load_valid held high across both words
    load_data  = 8'hFF;
    load_inv   = 1'b0;
    load_valid = 1'b1;
    ser_ready  = 1'b1;
    tick();
    cycles    = 0;
    load_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check("b2b_w1_data", ser_data, 1'b1);
      check("b2b_w1_last", ser_last, (k == 7));
      tick();
      cycles++;
    end
    check("b2b_bubble_ready", load_ready, 1'b1);
    check("b2b_bubble_valid", ser_valid, 1'b0);
    tick();
    cycles++;
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("b2b_w2_valid", ser_valid, 1'b1);
      check("b2b_w2_data", ser_data, 1'b0);
      tick();
      cycles++;
    end
    check("b2b_cycles", cycles, 17);
    check("b2b_end_ready", load_ready, 1'b1);

    // Reset in the middle of a word
    load_data  = 8'h81;
    load_inv   = 1'b0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("mid_first_bit", ser_data, 1'b1);
    repeat (3) tick();
    check("mid_pre_rst_valid", ser_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ser_valid, 1'b0);
    check("mid_rst_ready", load_ready, 1'b1);
    check("mid_rst_data", ser_data, 1'b0);
    check("mid_rst_last", ser_last, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_post_ready", load_ready, 1'b1);
    send_word(8'h80, 1'b0, 8'b1000_0000, -1, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mux_serializer
`default_nettype wire
